// File: rtl/instruction_fetch_unit.sv
// Pipeline stage 0: owns the PC, issues instruction reads, buffers one word.
// Ports: clk/rst, flow control (stepPipe/stallPipe/progressPipe), fetchEnable,
//   jump redirect (jumpEnable/jumpAddress), instruction memory port,
//   requestingInstruction/instructionBusy status, pipe0_* stage outputs and
//   the sticky fetchMisaligned flag.
module instruction_fetch_unit #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_ADDRESS = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetchEnable,
    input  logic                     stepPipe,
    input  logic                     stallPipe,
    input  logic                     progressPipe,
    input  logic                     jumpEnable,
    input  logic [ADDRESS_WIDTH-1:0] jumpAddress,
    output logic [ADDRESS_WIDTH-1:0] instruction_memoryAddress,
    output logic                     instruction_memoryReadEnable,
    input  logic [31:0]              instruction_memoryDataRead,
    input  logic                     instruction_memoryBusy,
    output logic                     requestingInstruction,
    output logic                     instructionBusy,
    output logic                     pipe0_active,
    output logic [ADDRESS_WIDTH-1:0] pipe0_programCounter,
    output logic [31:0]              pipe0_instruction,
    output logic                     fetchMisaligned
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        ERROR
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] buf_pc;
    logic [31:0]              buf_word;

    logic advance;
    logic redirect;
    logic jump_misaligned;
    logic capture_mem;
    logic capture_buf;
    logic to_hold;
    logic idle_bubble;

    assign advance = stepPipe && progressPipe && !stallPipe;

    // A redirect wins over any capture; the returned word is dropped.
    assign redirect        = advance && jumpEnable && (state != ERROR);
    assign jump_misaligned = |jumpAddress[1:0];

    assign capture_mem = !redirect && advance
                       && (state == FETCH) && !instruction_memoryBusy;
    assign capture_buf = !redirect && advance && (state == HOLD);

    // Word returned while the pipe cannot take it (including a stall).
    assign to_hold = (state == FETCH) && !instruction_memoryBusy && !advance;

    assign idle_bubble = !redirect && advance && (state == IDLE);

    assign instruction_memoryAddress    = pc;
    assign instruction_memoryReadEnable = (state == FETCH);
    assign requestingInstruction        = instruction_memoryReadEnable;
    assign instructionBusy              = instruction_memoryBusy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect) begin
            if (jump_misaligned) begin
                state_next = ERROR;
            end else begin
                state_next = fetchEnable ? FETCH : IDLE;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (fetchEnable) begin
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    if (!instruction_memoryBusy) begin
                        if (advance) begin
                            state_next = fetchEnable ? FETCH : IDLE;
                        end else begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // The buffer survives fetchEnable dropping.
                    if (advance) begin
                        state_next = fetchEnable ? FETCH : IDLE;
                    end
                end
                ERROR: begin
                    state_next = ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc                   <= RESET_ADDRESS;
            buf_pc               <= '0;
            buf_word             <= '0;
            pipe0_active         <= 1'b0;
            pipe0_programCounter <= '0;
            pipe0_instruction    <= '0;
            fetchMisaligned      <= 1'b0;
        end else begin
            if (redirect) begin
                pipe0_active <= 1'b0;
                if (jump_misaligned) begin
                    fetchMisaligned <= 1'b1;
                end else begin
                    pc <= jumpAddress;
                end
            end else if (capture_mem) begin
                pipe0_active         <= 1'b1;
                pipe0_programCounter <= pc;
                pipe0_instruction    <= instruction_memoryDataRead;
                pc                   <= pc + ADDRESS_WIDTH'(4);
            end else if (capture_buf) begin
                pipe0_active         <= 1'b1;
                pipe0_programCounter <= buf_pc;
                pipe0_instruction    <= buf_word;
                pc                   <= pc + ADDRESS_WIDTH'(4);
            end else if (idle_bubble) begin
                pipe0_active <= 1'b0;
            end

            if (to_hold) begin
                buf_word <= instruction_memoryDataRead;
                buf_pc   <= pc;
            end
        end
    end

endmodule
